// File: rtl/regfile_read_arbiter_if.sv
// Bundle of the three-requester read request bus, the register-file mux hookup
// and the single response channel shared by the read arbiter.
interface regfile_read_arbiter_if #(
   parameter int N = 32
);
   logic [2:0]   req_valid;
   logic [4:0]   req_addr_0;
   logic [4:0]   req_addr_1;
   logic [4:0]   req_addr_2;
   logic [2:0]   req_ready;
   logic [4:0]   rf_sel;
   logic [N-1:0] rf_data;
   logic         rsp_valid;
   logic [1:0]   rsp_id;
   logic [N-1:0] rsp_data;
   logic         rsp_ready;

   // Requesters, register-file mux and response consumer live on the master side.
   modport master (
      output req_valid, req_addr_0, req_addr_1, req_addr_2, rf_data, rsp_ready,
      input  req_ready, rf_sel, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_addr_0, req_addr_1, req_addr_2, rf_data, rsp_ready,
      output req_ready, rf_sel, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among three requesters,
// with a single-entry registered response that supports one response per cycle.
module regfile_read_arbiter #(
   parameter int N = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   regfile_read_arbiter_if.slave   bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t       state_reg;
   state_t       state_next;
   logic [1:0]   last_grant_reg;
   logic [1:0]   rsp_id_reg;
   logic [N-1:0] rsp_data_reg;

   logic         can_accept;
   logic         grant_any;
   logic [1:0]   grant_idx;
   logic [2:0]   grant_oh;
   logic [4:0]   sel;
   int           cand;

   // Arbitration: search starts one past the last winner, so every requester
   // gets a turn within three grants.
   always_comb begin
      can_accept = (state_reg == EMPTY) || bus.rsp_ready;
      grant_any  = 1'b0;
      grant_idx  = 2'd0;
      cand       = 0;
      if (!reset && can_accept) begin
         for (int k = 0; k < 3; k++) begin
            cand = (int'(last_grant_reg) + 1 + k) % 3;
            if (!grant_any && bus.req_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = 2'(cand);
            end
         end
      end
   end

   always_comb begin
      grant_oh = 3'b000;
      sel      = 5'd0;
      if (grant_any) begin
         case (grant_idx)
            2'd0:    begin grant_oh = 3'b001; sel = bus.req_addr_0; end
            2'd1:    begin grant_oh = 3'b010; sel = bus.req_addr_1; end
            default: begin grant_oh = 3'b100; sel = bus.req_addr_2; end
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: if (grant_any) state_next = FULL;
         FULL: begin
            if (grant_any)          state_next = FULL;
            else if (bus.rsp_ready) state_next = EMPTY;
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= EMPTY;
      else       state_reg <= state_next;
   end

   // Register x0 is hardwired to zero whatever the mux presents.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_id_reg     <= 2'd0;
         rsp_data_reg   <= '0;
         last_grant_reg <= 2'd2;
      end else if (grant_any) begin
         rsp_id_reg     <= grant_idx;
         rsp_data_reg   <= (sel == 5'd0) ? '0 : bus.rf_data;
         last_grant_reg <= grant_idx;
      end
   end

   assign bus.req_ready = grant_oh;
   assign bus.rf_sel    = sel;
   assign bus.rsp_valid = (state_reg == FULL);
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: expected responses are queued at grant
// time and compared while the response is presented to the consumer.
module tb_regfile_read_arbiter;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic force_ones = 1'b0;
   logic [31:0] rf_mem [32];
   rsp_t sb [$];
   int tests = 0;
   int fails = 0;

   regfile_read_arbiter_if #(.N(32)) bus ();

   regfile_read_arbiter #(.N(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always_comb bus.rf_data = force_ones ? 32'hFFFF_FFFF : rf_mem[bus.rf_sel];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("%s mismatch", tag);
      end
   endtask

   // One cycle: drive inputs after the falling edge, check the combinational
   // grant and the presented response, then update the scoreboard for the edge.
   task automatic step(input logic r, input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic rr, input logic [2:0] exp_rdy);
      logic [4:0]  exp_sel;
      logic [1:0]  exp_id;
      logic [31:0] exp_data;
      rsp_t        e;
      @(negedge clk);
      reset          = r;
      bus.req_valid  = v;
      bus.req_addr_0 = a0;
      bus.req_addr_1 = a1;
      bus.req_addr_2 = a2;
      bus.rsp_ready  = rr;
      #1;
      exp_id  = exp_rdy[0] ? 2'd0 : (exp_rdy[1] ? 2'd1 : 2'd2);
      exp_sel = (exp_rdy == 3'b000) ? 5'd0 : (exp_id == 2'd0 ? a0 : (exp_id == 2'd1 ? a1 : a2));
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rf_sel", 32'(bus.rf_sel), 32'(exp_sel));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk("rsp_id", 32'(bus.rsp_id), 32'(sb[0].id));
         chk("rsp_data", bus.rsp_data, sb[0].data);
         if (rr) void'(sb.pop_front());
      end
      if (r) begin
         sb.delete();
      end else if (exp_rdy != 3'b000) begin
         exp_data = force_ones ? 32'hFFFF_FFFF : rf_mem[exp_sel];
         if (exp_sel == 5'd0) exp_data = 32'h0;
         e.id   = exp_id;
         e.data = exp_data;
         sb.push_back(e);
         $display("[TB] grant req%0d addr %0d expect data %h", exp_id, exp_sel, exp_data);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      rf_mem[10]     = 32'hDEAD_BEEF;
      bus.req_valid  = 3'b000;
      bus.req_addr_0 = 5'd0;
      bus.req_addr_1 = 5'd0;
      bus.req_addr_2 = 5'd0;
      bus.rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);

      // Reset held with requests pending: no grants, empty response.
      step(1'b1, 3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 3'b000);
      chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("reset_rsp_data", bus.rsp_data, 32'd0);

      // All three requesting: 0,1,2,0 back to back.
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 3'b001);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 3'b010);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 3'b100);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 3'b001);
      step(1'b0, 3'b000, 5'd5, 5'd6, 5'd7, 1'b1, 3'b000);

      // Single request from requester 1 for x10.
      step(1'b0, 3'b010, 5'd0, 5'd10, 5'd0, 1'b1, 3'b010);
      step(1'b0, 3'b000, 5'd0, 5'd10, 5'd0, 1'b1, 3'b000);

      // Stall for three cycles with requests active; then resume at (last+1)%3.
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b0, 3'b100);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b0, 3'b000);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b0, 3'b000);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b0, 3'b000);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 3'b001);
      step(1'b0, 3'b000, 5'd5, 5'd6, 5'd7, 1'b1, 3'b000);

      // Address 0 reads as zero even with the mux driving all ones.
      force_ones = 1'b1;
      step(1'b0, 3'b100, 5'd3, 5'd3, 5'd0, 1'b1, 3'b100);
      step(1'b0, 3'b000, 5'd3, 5'd3, 5'd0, 1'b1, 3'b000);
      force_ones = 1'b0;

      // Reset while a response is pending discards it and restores priority to 0.
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b0, 3'b001);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b0, 3'b000);
      step(1'b1, 3'b111, 5'd5, 5'd6, 5'd7, 1'b0, 3'b000);
      step(1'b0, 3'b111, 5'd5, 5'd6, 5'd7, 1'b1, 3'b001);
      step(1'b0, 3'b000, 5'd5, 5'd6, 5'd7, 1'b1, 3'b000);

      // Requester 0 continuous, requester 1 pulsing: 1 wins each time it asks.
      step(1'b0, 3'b001, 5'd8, 5'd9, 5'd0, 1'b1, 3'b001);
      step(1'b0, 3'b011, 5'd8, 5'd9, 5'd0, 1'b1, 3'b010);
      step(1'b0, 3'b001, 5'd8, 5'd9, 5'd0, 1'b1, 3'b001);
      step(1'b0, 3'b011, 5'd8, 5'd11, 5'd0, 1'b1, 3'b010);
      step(1'b0, 3'b001, 5'd8, 5'd9, 5'd0, 1'b1, 3'b001);

      // Requester 2 drops out before its turn; turn passes on without disturbing order.
      step(1'b0, 3'b110, 5'd8, 5'd12, 5'd13, 1'b1, 3'b010);
      step(1'b0, 3'b011, 5'd8, 5'd12, 5'd13, 1'b1, 3'b001);
      step(1'b0, 3'b000, 5'd8, 5'd12, 5'd13, 1'b1, 3'b000);
      step(1'b0, 3'b000, 5'd8, 5'd12, 5'd13, 1'b1, 3'b000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 Parameter: N, default 32, data width of one register and of the shared read-port output.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  3  per-requester read request; bit i belongs to requester i.
REQ-006 req_addr_0, req_addr_1, req_addr_2  input  5 each  register index requested by requester 0/1/2.
REQ-007 req_ready  output  3  one-hot-or-zero grant; request i is accepted on a clock edge where req_valid[i] and req_ready[i] are both 1.
REQ-008 rf_sel  output  5  drives the selector of the 32:1 register-file read mux.
REQ-009 rf_data  input  N  output of the register-file read mux, combinational from rf_sel.
REQ-010 rsp_valid  output  1  response holding valid data.
REQ-011 rsp_id  output  2  requester index (0..2) that owns the response.
REQ-012 rsp_data  output  N  register value returned.
REQ-013 rsp_ready  input  1  consumer accepts the response on a clock edge where rsp_valid and rsp_ready are both 1.

Function
REQ-014 The block SHALL share the single register-file read port among three requesters, with one grant per cycle at most.
REQ-015 can_accept SHALL be 1 when rsp_valid is 0, or when rsp_valid and rsp_ready are both 1; otherwise 0.
REQ-016 When can_accept is 1 and any req_valid bit is 1, the block SHALL grant exactly one requester, using round-robin order starting at (last_grant+1) mod 3.
REQ-017 req_ready SHALL be combinational, with at most one bit set, and only for a requester whose req_valid is 1.
REQ-018 req_ready SHALL be all-zero when can_accept is 0 or req_valid is 0.
REQ-019 rf_sel SHALL equal req_addr of the granted requester in the grant cycle, and 5'd0 when nothing is granted.
REQ-020 On a grant edge the block SHALL register the following: rsp_data = rf_data (forced to 0 when the granted address is 0), rsp_id = granted index, rsp_valid = 1, last_grant = granted index.
REQ-021 Latency SHALL be exactly 1 cycle from grant edge to rsp_valid high.
REQ-022 On an edge where a response is accepted and no new grant occurs, rsp_valid SHALL become 0.
REQ-023 On an edge where a response is accepted and a new grant occurs, rsp_valid SHALL stay 1 with new contents, giving back-to-back throughput of 1 per cycle.
REQ-024 While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_id and rsp_data SHALL hold stable, and no grant SHALL occur.
REQ-025 last_grant SHALL change only on grant edges; a requester that deasserts req_valid before being granted SHALL lose no other requester's turn.
REQ-026 Address wrap rule: req_addr values are 0..31 and all are legal; index 0 SHALL always return 0, regardless of rf_data.
REQ-027 The state machine SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-028 State transitions: EMPTY->FULL on grant; FULL->FULL on stall, or on accept with a new grant; FULL->EMPTY on accept with no grant.

Reset
REQ-029 While reset is high at a clock edge, the block SHALL set rsp_valid=0, rsp_id=0, rsp_data=0 and last_grant=2, so requester 0 has first priority.
REQ-030 While reset is high, req_ready SHALL be 0 and rf_sel SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard any pending response; no grant SHALL be recorded on that edge.

Verification
REQ-032 Scenario: after reset, req_valid=3'b111, addrs 5/6/7, rsp_ready=1 held. Required: grants 0,1,2,0... on successive cycles; rsp_id sequence 0,1,2; rsp_data = contents of x5, x6, x7; one response per cycle.
REQ-033 Scenario: single request from requester 1 for addr 10 (x10=32'hDEADBEEF). Required: req_ready=3'b010 and rf_sel=10 in the same cycle; next cycle rsp_valid=1, rsp_id=1, rsp_data=32'hDEADBEEF.
REQ-034 Scenario: response pending, rsp_ready=0 for 3 cycles, with requests active. Required: req_ready=0 and the response held stable for all 3 cycles; after rsp_ready=1, the next grant goes to (last_grant+1) mod 3.
REQ-035 Scenario: requester 2, addr 0, with rf_data driven to 32'hFFFFFFFF. Required: rsp_data=0, rsp_id=2.
REQ-036 Scenario: reset asserted for 1 cycle while rsp_valid=1. Required: rsp_valid=0 after the edge; the next grant with all requesters valid goes to requester 0.
REQ-037 Scenario: requester 0 valid continuously, requester 1 pulsing. Required: requester 1 is granted within 2 cycles of asserting, so there is no starvation.
